// File: rtl/divu_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module divu_step
    import divu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted_low;
    logic [WIDTH:0]   low_sum;
    logic             carry;

    // The shifted remainder is WIDTH+1 bits wide. Its top bit meets the
    // divisor's zero extension (inverted to 1), so the carry out of the
    // WIDTH+1-bit add rem' + ~divisor + 1 is the top bit OR the low carry.
    always_comb begin
        shifted_low = {rem_in[WIDTH-2:0], dividend_msb};
        low_sum     = {1'b0, shifted_low} + {1'b0, ~divisor} + (WIDTH+1)'(1);
        carry       = rem_in[WIDTH-1] | low_sum[WIDTH];
        q_bit       = carry;
        rem_out     = carry ? low_sum[WIDTH-1:0] : shifted_low;
    end

endmodule

// File: rtl/divu_iter.sv
// Iterative restoring unsigned divider with valid/ready handshakes.
// Define DIVU_ITER_RADIX4_EN to retire two quotient bits per cycle.
module divu_iter
    import divu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

`ifdef DIVU_ITER_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif

    localparam int             CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - STEPS);
    localparam logic [CW-1:0]  COUNT_INC  = CW'(STEPS);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("divu_iter: WIDTH must be even and at least 4");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] dividend_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] rem_next;

    logic [WIDTH-1:0] rem0;
    logic             q0;

    divu_step #(.WIDTH(WIDTH)) u_step0 (
        .rem_in       (rem_q),
        .dividend_msb (dividend_q[WIDTH-1]),
        .divisor      (divisor_q),
        .rem_out      (rem0),
        .q_bit        (q0)
    );

`ifdef DIVU_ITER_RADIX4_EN
    logic [WIDTH-1:0] rem1;
    logic             q1;

    divu_step #(.WIDTH(WIDTH)) u_step1 (
        .rem_in       (rem0),
        .dividend_msb (dividend_q[WIDTH-2]),
        .divisor      (divisor_q),
        .rem_out      (rem1),
        .q_bit        (q1)
    );

    always_comb begin
        rem_next      = rem1;
        quot_next     = {quot_q[WIDTH-3:0], q0, q1};
        dividend_next = {dividend_q[WIDTH-3:0], 2'b00};
    end
`else
    always_comb begin
        rem_next      = rem0;
        quot_next     = {quot_q[WIDTH-2:0], q0};
        dividend_next = {dividend_q[WIDTH-2:0], 1'b0};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST_COUNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter advances by the number of steps per cycle and stops at WIDTH,
    // which still fits in its $clog2(WIDTH)+1 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            count      <= '0;
        end else if (accept) begin
            dividend_q <= i_dividend;
            divisor_q  <= i_divisor;
            quot_q     <= '0;
            rem_q      <= '0;
            count      <= '0;
        end else if (state == BUSY) begin
            dividend_q <= dividend_next;
            quot_q     <= quot_next;
            rem_q      <= rem_next;
            count      <= count + COUNT_INC;
        end
    end

    assign o_quotient  = quot_q;
    assign o_remainder = rem_q;

endmodule

// File: tb/tb_divu_iter.sv
// Self-checking bench for divu_iter: directed cases plus randomized operands
// checked against plain / and % arithmetic.
module tb_divu_iter;

    localparam int WIDTH = 32;
`ifdef DIVU_ITER_RADIX4_EN
    localparam int LAT = WIDTH / 2;
`else
    localparam int LAT = WIDTH;
`endif
    localparam int NUM_RANDOM = 1000;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;

    int checks   = 0;
    int failures = 0;

    divu_iter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned division as the arithmetic defines it, with the divide-by-zero
    // convention: all-ones quotient, dividend as remainder.
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid   = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        tick();
        in_valid   = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < LAT + 8) begin
            tick();
            cycles++;
        end
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready_low: got %0b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (o_quotient !== '0 || o_remainder !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got q=%0h r=%0h expected 0 0", o_quotient, o_remainder);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_in_ready: got %0b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_known_values;
        logic [WIDTH-1:0] ta [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd1234};
        logic [WIDTH-1:0] tb [4] = '{32'd7,   32'd1,         32'd9, 32'd0};
        logic [WIDTH-1:0] tq [4] = '{32'd14,  32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] tr [4] = '{32'd2,   32'd0,         32'd5, 32'd1234};
        int cycles;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(cycles);
            checks++;
            if (cycles !== LAT) begin
                failures++;
                $display("[TB] FAIL known_latency[%0d]: got %0d expected %0d", i, cycles, LAT);
            end
            checks++;
            if (o_quotient !== tq[i]) begin
                failures++;
                $display("[TB] FAIL known_quotient[%0d]: got %0h expected %0h", i, o_quotient, tq[i]);
            end
            checks++;
            if (o_remainder !== tr[i]) begin
                failures++;
                $display("[TB] FAIL known_remainder[%0d]: got %0h expected %0h", i, o_remainder, tr[i]);
            end
            release_result();
        end
    endtask

    task automatic test_hold_done;
        int cycles;
        start_op(32'd77, 32'd5);
        wait_done(cycles);
        checks++;
        if (cycles !== LAT) begin
            failures++;
            $display("[TB] FAIL hold_latency: got %0d expected %0d", cycles, LAT);
        end
        in_valid   = 1'b1;
        i_dividend = 32'd1000;
        i_divisor  = 32'd10;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_handshake[%0d]: got valid=%0b ready=%0b expected 1 0", k, out_valid, in_ready);
            end
            checks++;
            if (o_quotient !== 32'd15 || o_remainder !== 32'd2) begin
                failures++;
                $display("[TB] FAIL hold_result[%0d]: got q=%0d r=%0d expected 15 2", k, o_quotient, o_remainder);
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_release: got valid=%0b ready=%0b expected 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_ignored_op: got in_ready=%0b expected 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_op;
        int cycles;
        int stray;
        start_op(32'd50, 32'd3);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_handshake: got valid=%0b ready=%0b expected 0 0", out_valid, in_ready);
        end
        checks++;
        if (o_quotient !== '0 || o_remainder !== '0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got q=%0h r=%0h expected 0 0", o_quotient, o_remainder);
        end
        tick();
        rst   = 1'b0;
        stray = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (out_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_result: got %0d valid cycles expected 0", stray);
        end
        start_op(32'd9, 32'd4);
        wait_done(cycles);
        checks++;
        if (cycles !== LAT || o_quotient !== 32'd2 || o_remainder !== 32'd1) begin
            failures++;
            $display("[TB] FAIL post_reset_op: got lat=%0d q=%0d r=%0d expected %0d 2 1", cycles, o_quotient, o_remainder, LAT);
        end
        release_result();
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] pa [5];
        logic [WIDTH-1:0] pb [5];
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        int cycles;
        for (int i = 0; i < 5; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom_range(1, 1000);
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        i_dividend = pa[0];
        i_divisor  = pb[0];
        for (int k = 0; k < 4; k++) begin
            tick();
            i_dividend = pa[k+1];
            i_divisor  = pb[k+1];
            wait_done(cycles);
            ref_div(pa[k], pb[k], eq, er);
            checks++;
            if (cycles !== LAT || o_quotient !== eq || o_remainder !== er) begin
                failures++;
                $display("[TB] FAIL b2b[%0d]: got lat=%0d q=%0h r=%0h expected %0d %0h %0h", k, cycles, o_quotient, o_remainder, LAT, eq, er);
            end
            tick();
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_idle[%0d]: got in_ready=%0b expected 1", k, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        int cycles;
        int mode;
        for (int n = 0; n < NUM_RANDOM; n++) begin
            a    = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = $urandom >> $urandom_range(0, 31);
                3: b = ($urandom_range(0, 3) == 0) ? '0 : a;
                default: begin
                    a = a >> $urandom_range(0, 31);
                    b = $urandom | 32'h8000_0000;
                end
            endcase
            ref_div(a, b, eq, er);
            start_op(a, b);
            wait_done(cycles);
            checks++;
            if (cycles !== LAT) begin
                failures++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, cycles, LAT);
            end
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (o_quotient !== eq) begin
                failures++;
                $display("[TB] FAIL rand_quotient[%0d] %0h/%0h: got %0h expected %0h", n, a, b, o_quotient, eq);
            end
            checks++;
            if (o_remainder !== er) begin
                failures++;
                $display("[TB] FAIL rand_remainder[%0d] %0h/%0h: got %0h expected %0h", n, a, b, o_remainder, er);
            end
            release_result();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_known_values();
        test_hold_done();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
